// File: rtl/fpu_ftoi_pipe.sv
// Two-stage float32 to int32 converter: round to nearest (ties away from zero), saturating.
// Stage 1 classifies the operand and pre-adds the rounding half; stage 2 shifts, negates, clamps.
module fpu_ftoi_pipe #(
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
);

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q, s1_sign_d;
    logic             s1_sat_q, s1_sat_d;
    logic             s1_zero_q, s1_zero_d;
    logic             s1_left_q, s1_left_d;
    logic [4:0]       s1_shamt_q, s1_shamt_d;
    logic [24:0]      s1_mant_q, s1_mant_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    // Stage 2 state
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_data_q, s2_data_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic s1_en, s2_en;

    // Decode of the incoming operand
    logic        dec_sign;
    logic [7:0]  dec_exp;
    logic [23:0] dec_man;
    logic        dec_sat, dec_zero, dec_left;
    logic [4:0]  dec_shamt;
    logic [23:0] dec_half;
    logic [24:0] dec_mant;

    // Stage 2 datapath
    logic [31:0] mag;
    logic [31:0] s2_result;

    assign s2_en    = ~s2_valid_q | out_ready;
    assign s1_en    = ~s1_valid_q | s2_en;
    assign in_ready = s1_en | ~rstn;

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;

    always_comb begin
        dec_sign = in_data[31];
        dec_exp  = in_data[30:23];
        dec_man  = {1'b1, in_data[22:0]};
        dec_sat  = (dec_exp == 8'd255) || (dec_exp >= 8'd158);
        dec_zero = (dec_exp <= 8'd125);
        dec_left = (dec_exp >= 8'd150);
        // 150 mod 32 = 22, and both shift ranges (0..7, 1..24) fit in 5 bits.
        if (dec_left) begin
            dec_shamt = dec_exp[4:0] - 5'd22;
        end else begin
            dec_shamt = 5'd22 - dec_exp[4:0];
        end
        dec_half = 24'd1 << (dec_shamt - 5'd1);
        if (dec_left) begin
            dec_mant = {1'b0, dec_man};
        end else begin
            dec_mant = {1'b0, dec_man} + {1'b0, dec_half};
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_sat_d   = s1_sat_q;
        s1_zero_d  = s1_zero_q;
        s1_left_d  = s1_left_q;
        s1_shamt_d = s1_shamt_q;
        s1_mant_d  = s1_mant_q;
        s1_tag_d   = s1_tag_q;
        if (s1_en) begin
            s1_valid_d = in_valid;
        end
        if (flush) begin
            s1_valid_d = 1'b0;
        end
        if (s1_en && in_valid) begin
            s1_sign_d  = dec_sign;
            s1_sat_d   = dec_sat;
            s1_zero_d  = dec_zero;
            s1_left_d  = dec_left;
            s1_shamt_d = dec_shamt;
            s1_mant_d  = dec_mant;
            s1_tag_d   = in_tag;
        end
    end

    always_comb begin
        if (s1_left_q) begin
            mag = {7'd0, s1_mant_q} << s1_shamt_q;
        end else begin
            mag = {7'd0, s1_mant_q} >> s1_shamt_q;
        end
        if (s1_sat_q) begin
            s2_result = s1_sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (s1_zero_q) begin
            s2_result = 32'd0;
        end else if (s1_sign_q) begin
            s2_result = ~mag + 32'd1;
        end else begin
            s2_result = mag;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_tag_d   = s2_tag_q;
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
        end
        if (flush) begin
            s2_valid_d = 1'b0;
        end
        // Result registers only move when a real operation advances, so they hold under stall.
        if (s2_en && s1_valid_q) begin
            s2_data_d = s2_result;
            s2_tag_d  = s1_tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_sat_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_left_q  <= 1'b0;
            s1_shamt_q <= 5'd0;
            s1_mant_q  <= 25'd0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= 32'd0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_sat_q   <= s1_sat_d;
            s1_zero_q  <= s1_zero_d;
            s1_left_q  <= s1_left_d;
            s1_shamt_q <= s1_shamt_d;
            s1_mant_q  <= s1_mant_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

endmodule

// File: tb/tb_fpu_ftoi_pipe.sv
// Directed and random checks of fpu_ftoi_pipe: conversions, handshake, stall, flush and reset.
module tb_fpu_ftoi_pipe;

    localparam int unsigned TAG_W = 6;

    logic             clk;
    logic             rstn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    fpu_ftoi_pipe #(.TAG_W(TAG_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned      checks = 0;
    int unsigned      errors = 0;
    int unsigned      n_out  = 0;
    logic [31:0]      exp_data;
    logic [TAG_W-1:0] tag_ctr = '0;
    logic [TAG_W+31:0] sb_q[$];
    logic [TAG_W+31:0] sb_ent;

    logic [31:0] basic_in  [5] = '{32'h3F80_0000, 32'h4020_0000, 32'hC020_0000,
                                   32'h3EFF_FFFF, 32'h3F00_0000};
    logic [31:0] basic_exp [5] = '{32'h0000_0001, 32'h0000_0003, 32'hFFFF_FFFD,
                                   32'h0000_0000, 32'h0000_0001};
    logic [31:0] spec_in   [10] = '{32'h4F00_0000, 32'hCF00_0000, 32'h7FC0_0000,
                                    32'hFF80_0000, 32'h8000_0000, 32'h0000_0001,
                                    32'h4EFF_FFFF, 32'hCEFF_FFFF, 32'h4B7F_FFFF,
                                    32'h4AFF_FFFF};
    logic [31:0] spec_exp  [10] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                                    32'h8000_0000, 32'h0000_0000, 32'h0000_0000,
                                    32'h7FFF_FF80, 32'h8000_0080, 32'h00FF_FFFF,
                                    32'h0080_0000};
    logic [31:0] bp_in     [5] = '{32'h4040_0000, 32'hC0A0_0000, 32'h3FC0_0000,
                                   32'h42C8_0000, 32'hBF40_0000};
    logic [31:0] bp_exp    [5] = '{32'h0000_0003, 32'hFFFF_FFFB, 32'h0000_0002,
                                   32'h0000_0064, 32'hFFFF_FFFF};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference conversion by integer division with explicit remainder test.
    function automatic logic [31:0] ref_ftoi(input logic [31:0] f);
        int          e;
        longint      m, q, r, k, mag;
        logic [31:0] res;
        e = int'(f[30:23]);
        m = longint'({1'b1, f[22:0]});
        if (e == 255 || e >= 158) return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        if (e <= 125) return 32'd0;
        if (e >= 150) begin
            mag = m * (longint'(1) << (e - 150));
        end else begin
            k = longint'(1) << (150 - e);
            q = m / k;
            r = m % k;
            mag = (2 * r >= k) ? q + 1 : q;
        end
        res = mag[31:0];
        return f[31] ? (32'd0 - res) : res;
    endfunction

    // Scoreboard: decisions are taken mid-cycle for the coming rising edge.
    always @(negedge clk) begin
        if (!rstn) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                check("out_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    sb_ent = sb_q.pop_front();
                    check("out_tag", 64'(out_tag), 64'(sb_ent[TAG_W+31:32]));
                    check("out_data", 64'(out_data), 64'(sb_ent[31:0]));
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back({in_tag, exp_data});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [31:0] e);
        int n;
        bit acc;
        in_valid = 1'b1;
        in_data  = d;
        exp_data = e;
        in_tag   = tag_ctr;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready && !flush;
            step();
            n++;
        end
        check("send_accept", 64'(acc), 64'd1);
        in_valid = 1'b0;
        tag_ctr++;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30; i++) begin
            if (sb_q.size() == 0 && !out_valid) break;
            step();
        end
        check("drain", 64'(sb_q.size() == 0 && !out_valid), 64'd1);
    endtask

    task automatic latency_check(input logic [31:0] d, input logic [31:0] e, input string name);
        in_valid = 1'b1;
        in_data  = d;
        exp_data = e;
        in_tag   = tag_ctr;
        check({name, "_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        tag_ctr++;
        check({name, "_k"}, 64'(out_valid), 64'd0);
        step();
        check({name, "_k1_valid"}, 64'(out_valid), 64'd1);
        check({name, "_k1_data"}, 64'(out_data), 64'(e));
        step();
        check({name, "_k2_empty"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int unsigned n0;
        int unsigned sent;
        bit          pending;
        bit          acc;
        logic [31:0] f;
        logic [7:0]  ex;

        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_tag    = '0;
        out_ready = 1'b0;
        exp_data  = 32'd0;
        #1;
        check("rst_in_ready_during", 64'(in_ready), 64'd1);
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        rstn = 1'b1;
        check("rst_in_ready_after", 64'(in_ready), 64'd1);

        // Latency
        out_ready = 1'b1;
        latency_check(32'h3F80_0000, 32'd1, "lat");

        // Back-to-back basic conversions
        n0 = n_out;
        for (int i = 0; i < 5; i++) send(basic_in[i], basic_exp[i]);
        check("stream_full", 64'(out_valid), 64'd1);
        wait_drain();
        check("stream_count", 64'(n_out - n0), 64'd5);

        // Saturation and specials
        for (int i = 0; i < 10; i++) send(spec_in[i], spec_exp[i]);
        wait_drain();

        // Backpressure: two held, then a 4-cycle stall with a third offered
        out_ready = 1'b0;
        n0 = n_out;
        send(bp_in[0], bp_exp[0]);
        send(bp_in[1], bp_exp[1]);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = bp_in[2];
        exp_data = bp_exp[2];
        in_tag   = tag_ctr;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_stall_ready", 64'(in_ready), 64'd0);
            check("bp_stall_valid", 64'(out_valid), 64'd1);
            check("bp_stall_data", 64'(out_data), 64'(bp_exp[0]));
            check("bp_stall_tag", 64'(out_tag), 64'(tag_ctr - 6'd2));
        end
        out_ready = 1'b1;
        for (int i = 2; i < 5; i++) send(bp_in[i], bp_exp[i]);
        wait_drain();
        check("bp_count", 64'(n_out - n0), 64'd5);

        // Flush with two in flight and a third offered
        out_ready = 1'b0;
        n0 = n_out;
        send(32'h3F80_0000, 32'd1);
        send(32'h4020_0000, 32'd3);
        in_valid = 1'b1;
        in_data  = 32'h4040_0000;
        exp_data = 32'd3;
        in_tag   = tag_ctr;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        tag_ctr++;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("flush_no_output", 64'(out_valid), 64'd0);
        end
        check("flush_count", 64'(n_out - n0), 64'd0);

        // Flush beats an input transfer on an empty pipe
        in_valid = 1'b1;
        in_data  = 32'h4120_0000;
        exp_data = 32'd10;
        in_tag   = tag_ctr;
        flush    = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        tag_ctr++;
        for (int i = 0; i < 3; i++) begin
            check("flush_drop", 64'(out_valid), 64'd0);
            step();
        end

        // Reset mid-operation
        out_ready = 1'b0;
        send(32'h4040_0000, 32'd3);
        send(32'hC0A0_0000, 32'hFFFF_FFFB);
        rstn = 1'b0;
        step();
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_data", 64'(out_data), 64'd0);
        check("rst_mid_tag", 64'(out_tag), 64'd0);
        rstn = 1'b1;
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        latency_check(32'h4120_0000, 32'd10, "rst_lat");

        // Random sweep with random gaps and backpressure
        sent    = 0;
        pending = 1'b0;
        while (sent < 3000) begin
            if (!pending && $urandom_range(3) != 0) begin
                ex = ($urandom_range(9) < 7) ? 8'($urandom_range(160, 122))
                                             : 8'($urandom_range(255, 0));
                f  = {1'($urandom_range(1)), ex, 23'($urandom)};
                in_valid = 1'b1;
                in_data  = f;
                exp_data = ref_ftoi(f);
                in_tag   = tag_ctr;
                pending  = 1'b1;
            end
            out_ready = 1'($urandom_range(1));
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                pending  = 1'b0;
                in_valid = 1'b0;
                sent++;
                tag_ctr++;
            end
        end
        out_ready = 1'b1;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
